// File: rtl/bp_pkg.sv
// Shared types and sizing for the branch resolution queue.
package bp_pkg;

    localparam int unsigned BRQ_DEPTH = 8;
    localparam int unsigned BRQ_PC_W  = 32;
    localparam int unsigned BRQ_PTR_W = $clog2(BRQ_DEPTH);

    typedef struct packed {
        logic [BRQ_PC_W-1:0] pc;
        logic                pred_br;
        logic                glob_pred;
        logic                loc_pred;
    } brq_entry_t;

endpackage

// File: rtl/brq_ring.sv
// Circular buffer of predicted-branch entries with head/tail/count and a flush clear.
module brq_ring
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = BRQ_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       push,
    input  logic       pop,
    input  brq_entry_t wdata,
    output brq_entry_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0] head;
    logic [PtrW-1:0] tail;
    logic [PtrW:0]   count;
    brq_entry_t      mem [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full    = (count == (PtrW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A full ring still accepts a push when the head frees a slot in the same cycle.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = mem[head];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_ok) tail <= tail + 1'b1;
            if (pop_ok)  head <= head + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && push_ok) mem[tail] <= wdata;
    end

endmodule

// File: rtl/branch_resolution_queue.sv
// Pairs in-order fetch predictions with execute resolutions; drives predictor update and flush.
// Optional BRQ_STATS_EN adds saturating branch/mispredict counters.
module branch_resolution_queue
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH    = BRQ_DEPTH,
    parameter int unsigned PC_WIDTH = BRQ_PC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enq_valid,
    input  logic [PC_WIDTH-1:0] enq_pc,
    input  logic                enq_pred_br,
    input  logic                enq_glob_pred,
    input  logic                enq_loc_pred,
    output logic                full,
    input  logic                res_valid,
    input  logic                res_br_en,
    output logic                pred_ld,
    output logic                br_en,
    output logic [PC_WIDTH-1:0] upd_pc,
    output logic                glob_correct,
    output logic                loc_correct,
    output logic                mispredict,
`ifdef BRQ_STATS_EN
    output logic [31:0]         stat_branches,
    output logic [31:0]         stat_mispred,
`endif
    output logic                res_err
);

    brq_entry_t wentry;
    brq_entry_t head_entry;
    logic       ring_empty;
    logic       pop;
    logic       mis_now;

    assign wentry = '{pc: BRQ_PC_W'(enq_pc), pred_br: enq_pred_br,
                      glob_pred: enq_glob_pred, loc_pred: enq_loc_pred};

    assign pop     = res_valid && !ring_empty;
    assign mis_now = pop && (head_entry.pred_br != res_br_en);

    // Mispredict clears the ring: everything younger is wrong-path, including a same-cycle push.
    brq_ring #(
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (clk),
        .rst   (rst),
        .clear (mis_now),
        .push  (enq_valid),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head_entry),
        .full  (full),
        .empty (ring_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pred_ld      <= 1'b0;
            br_en        <= 1'b0;
            upd_pc       <= '0;
            glob_correct <= 1'b0;
            loc_correct  <= 1'b0;
            mispredict   <= 1'b0;
            res_err      <= 1'b0;
        end else begin
            pred_ld      <= pop;
            br_en        <= pop && res_br_en;
            glob_correct <= pop && (head_entry.glob_pred == res_br_en);
            loc_correct  <= pop && (head_entry.loc_pred == res_br_en);
            mispredict   <= mis_now;
            if (pop) upd_pc <= PC_WIDTH'(head_entry.pc);
            if (res_valid && ring_empty) res_err <= 1'b1;
        end
    end

`ifdef BRQ_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            if (pop && (stat_branches != '1)) stat_branches <= stat_branches + 1'b1;
            if (mis_now && (stat_mispred != '1)) stat_mispred <= stat_mispred + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed self-checking bench for branch_resolution_queue (DEPTH=8, PC_WIDTH=32).
module tb_branch_resolution_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic [31:0] enq_pc = '0;
    logic        enq_pred_br = 1'b0;
    logic        enq_glob_pred = 1'b0;
    logic        enq_loc_pred = 1'b0;
    logic        full;
    logic        res_valid = 1'b0;
    logic        res_br_en = 1'b0;
    logic        pred_ld;
    logic        br_en;
    logic [31:0] upd_pc;
    logic        glob_correct;
    logic        loc_correct;
    logic        mispredict;
    logic        res_err;
`ifdef BRQ_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    branch_resolution_queue dut (
        .clk           (clk),
        .rst           (rst),
        .enq_valid     (enq_valid),
        .enq_pc        (enq_pc),
        .enq_pred_br   (enq_pred_br),
        .enq_glob_pred (enq_glob_pred),
        .enq_loc_pred  (enq_loc_pred),
        .full          (full),
        .res_valid     (res_valid),
        .res_br_en     (res_br_en),
        .pred_ld       (pred_ld),
        .br_en         (br_en),
        .upd_pc        (upd_pc),
        .glob_correct  (glob_correct),
        .loc_correct   (loc_correct),
        .mispredict    (mispredict),
`ifdef BRQ_STATS_EN
        .stat_branches (stat_branches),
        .stat_mispred  (stat_mispred),
`endif
        .res_err       (res_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = 1'b0;
        res_valid = 1'b0;
        res_br_en = 1'b0;
    endtask

    task automatic set_enq(input logic [31:0] pc, input logic p, input logic g, input logic l);
        enq_valid     = 1'b1;
        enq_pc        = pc;
        enq_pred_br   = p;
        enq_glob_pred = g;
        enq_loc_pred  = l;
    endtask

    task automatic enq(input logic [31:0] pc, input logic p, input logic g, input logic l);
        set_enq(pc, p, g, l);
        cyc();
        idle_inputs();
    endtask

    task automatic res(input logic b);
        res_valid = 1'b1;
        res_br_en = b;
        cyc();
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // Test 1: reset state and single predict/resolve.
        do_reset();
        chk("rst_pred_ld", {31'b0, pred_ld}, 32'd0);
        chk("rst_br_en", {31'b0, br_en}, 32'd0);
        chk("rst_upd_pc", upd_pc, 32'd0);
        chk("rst_glob_correct", {31'b0, glob_correct}, 32'd0);
        chk("rst_loc_correct", {31'b0, loc_correct}, 32'd0);
        chk("rst_mispredict", {31'b0, mispredict}, 32'd0);
        chk("rst_res_err", {31'b0, res_err}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);

        enq(32'h100, 1'b1, 1'b1, 1'b0);
        res(1'b1);
        chk("t1_pred_ld", {31'b0, pred_ld}, 32'd1);
        chk("t1_br_en", {31'b0, br_en}, 32'd1);
        chk("t1_upd_pc", upd_pc, 32'h100);
        chk("t1_glob_correct", {31'b0, glob_correct}, 32'd1);
        chk("t1_loc_correct", {31'b0, loc_correct}, 32'd0);
        chk("t1_mispredict", {31'b0, mispredict}, 32'd0);
        cyc();
        chk("t1_pred_ld_drop", {31'b0, pred_ld}, 32'd0);
        chk("t1_upd_pc_hold", upd_pc, 32'h100);

        // Test 2: fill to DEPTH, drop 9th, drain in order, then underflow.
        for (int i = 0; i < 8; i++) begin
            chk("t2_not_full", {31'b0, full}, 32'd0);
            enq(32'h200 + 32'(i * 4), 1'b1, 1'b1, i[0]);
        end
        chk("t2_full", {31'b0, full}, 32'd1);
        enq(32'h300, 1'b1, 1'b1, 1'b1);
        chk("t2_full_after_drop", {31'b0, full}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            res(1'b1);
            chk("t2_pred_ld", {31'b0, pred_ld}, 32'd1);
            chk("t2_upd_pc", upd_pc, 32'h200 + 32'(i * 4));
            chk("t2_loc_correct", {31'b0, loc_correct}, {31'b0, i[0]});
            chk("t2_mispredict", {31'b0, mispredict}, 32'd0);
        end
        chk("t2_drained_full", {31'b0, full}, 32'd0);
        chk("t2_res_err_clear", {31'b0, res_err}, 32'd0);
        res(1'b1);
        chk("t2_underflow_pred_ld", {31'b0, pred_ld}, 32'd0);
        chk("t2_underflow_res_err", {31'b0, res_err}, 32'd1);
        cyc();
        chk("t2_res_err_sticky", {31'b0, res_err}, 32'd1);
        do_reset();
        chk("t2_res_err_reset", {31'b0, res_err}, 32'd0);

        // Test 3: full queue with simultaneous enqueue and resolve.
        for (int i = 0; i < 8; i++) enq(32'h400 + 32'(i * 4), 1'b0, 1'b0, 1'b0);
        set_enq(32'h500, 1'b0, 1'b0, 1'b0);
        res_valid = 1'b1;
        res_br_en = 1'b0;
        cyc();
        idle_inputs();
        chk("t3_pred_ld", {31'b0, pred_ld}, 32'd1);
        chk("t3_upd_pc", upd_pc, 32'h400);
        chk("t3_still_full", {31'b0, full}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            res(1'b0);
            chk("t3_upd_pc_old", upd_pc, 32'h400 + 32'(i * 4));
        end
        res(1'b0);
        chk("t3_upd_pc_new", upd_pc, 32'h500);
        chk("t3_empty_full", {31'b0, full}, 32'd0);

        // Test 4: mispredict flushes younger entries and a same-cycle enqueue.
        enq(32'h600, 1'b0, 1'b0, 1'b1);
        enq(32'h604, 1'b1, 1'b1, 1'b1);
        enq(32'h608, 1'b1, 1'b1, 1'b1);
        set_enq(32'h60C, 1'b1, 1'b1, 1'b1);
        res_valid = 1'b1;
        res_br_en = 1'b1;
        cyc();
        idle_inputs();
        chk("t4_pred_ld", {31'b0, pred_ld}, 32'd1);
        chk("t4_mispredict", {31'b0, mispredict}, 32'd1);
        chk("t4_upd_pc", upd_pc, 32'h600);
        chk("t4_br_en", {31'b0, br_en}, 32'd1);
        chk("t4_glob_correct", {31'b0, glob_correct}, 32'd0);
        chk("t4_loc_correct", {31'b0, loc_correct}, 32'd1);
        chk("t4_res_err_before", {31'b0, res_err}, 32'd0);
        res(1'b1);
        chk("t4_flushed_pred_ld", {31'b0, pred_ld}, 32'd0);
        chk("t4_flushed_res_err", {31'b0, res_err}, 32'd1);

        // Test 5: reset mid-stream with 5 entries, reset beats a pending resolve.
        do_reset();
        for (int i = 0; i < 5; i++) enq(32'h700 + 32'(i * 4), 1'b1, 1'b1, 1'b1);
        rst = 1'b1;
        res_valid = 1'b1;
        res_br_en = 1'b0;
        cyc();
        idle_inputs();
        rst = 1'b0;
        chk("t5_full", {31'b0, full}, 32'd0);
        chk("t5_pred_ld", {31'b0, pred_ld}, 32'd0);
        chk("t5_mispredict", {31'b0, mispredict}, 32'd0);
        chk("t5_upd_pc", upd_pc, 32'd0);
        chk("t5_res_err", {31'b0, res_err}, 32'd0);
        for (int i = 0; i < 7; i++) enq(32'h800 + 32'(i * 4), 1'b1, 1'b1, 1'b1);
        chk("t5_seven_not_full", {31'b0, full}, 32'd0);
        enq(32'h81C, 1'b1, 1'b1, 1'b1);
        chk("t5_eight_full", {31'b0, full}, 32'd1);
        res(1'b1);
        chk("t5_first_after_reset", upd_pc, 32'h800);

`ifdef BRQ_STATS_EN
        // Test 6: counters over 10 resolves with 3 mispredicts.
        do_reset();
        chk("t6_stat_branches_rst", stat_branches, 32'd0);
        chk("t6_stat_mispred_rst", stat_mispred, 32'd0);
        for (int i = 0; i < 10; i++) begin
            enq(32'h900 + 32'(i * 4), 1'b1, 1'b1, 1'b1);
            res((i == 2 || i == 5 || i == 8) ? 1'b0 : 1'b1);
        end
        chk("t6_stat_branches", stat_branches, 32'd10);
        chk("t6_stat_mispred", stat_mispred, 32'd3);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
